rx_cp_remover: RTL



---
 rtl/rx_pkg.sv | 29 ++
 rtl/rx_cp_slicer.sv | 61 ++++++
 rtl/rx_cp_remover.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receive cyclic-prefix remover: stream geometry and FSM encoding.
package rx_pkg;

   localparam int unsigned SYM_LEN     = 80;
   localparam int unsigned GROUP_BEATS = 5;
   localparam int unsigned GROUP_SYMS  = 4;
   localparam int unsigned FFT_LEN     = 64;
   localparam int unsigned CP_LEN      = 16;
   localparam int unsigned CARRY_LANES = 48;

   typedef logic [2:0] phase_t;

   typedef enum logic {
      StIdle,
      StActive
   } state_e;

   // First CP lane within a beat for phases b0..b3; b4 carries no prefix.
   function automatic int unsigned cp_offset(input phase_t b);
      unique case (b)
         3'd0:    cp_offset = 0;
         3'd1:    cp_offset = 16;
         3'd2:    cp_offset = 32;
         3'd3:    cp_offset = 48;
         default: cp_offset = 0;
      endcase
   endfunction

endpackage

// File: rtl/rx_cp_slicer.sv
// Combinational lane mux: joins carried lanes with the current beat into one symbol and
// picks out the post-CP tail that becomes the next carry.
module rx_cp_slicer
   import rx_pkg::*;
#(
   parameter int unsigned BITWIDTH = 12
) (
   input  phase_t                                phase_i,
   input  logic [FFT_LEN-1:0][BITWIDTH-1:0]      beat_re_i,
   input  logic [FFT_LEN-1:0][BITWIDTH-1:0]      beat_im_i,
   input  logic [CARRY_LANES-1:0][BITWIDTH-1:0]  carry_re_i,
   input  logic [CARRY_LANES-1:0][BITWIDTH-1:0]  carry_im_i,
   output logic [FFT_LEN-1:0][BITWIDTH-1:0]      sym_re_o,
   output logic [FFT_LEN-1:0][BITWIDTH-1:0]      sym_im_o,
   output logic [CARRY_LANES-1:0][BITWIDTH-1:0]  carry_re_o,
   output logic [CARRY_LANES-1:0][BITWIDTH-1:0]  carry_im_o,
   output logic                                  emit_o
);

   always_comb begin
      sym_re_o   = '0;
      sym_im_o   = '0;
      carry_re_o = carry_re_i;
      carry_im_o = carry_im_i;
      emit_o     = 1'b0;
      unique case (phase_i)
         3'd0: begin
            carry_re_o = beat_re_i[63:16];
            carry_im_o = beat_im_i[63:16];
         end
         3'd1: begin
            emit_o            = 1'b1;
            sym_re_o          = {beat_re_i[15:0], carry_re_i[47:0]};
            sym_im_o          = {beat_im_i[15:0], carry_im_i[47:0]};
            carry_re_o[31:0]  = beat_re_i[63:32];
            carry_im_o[31:0]  = beat_im_i[63:32];
         end
         3'd2: begin
            emit_o            = 1'b1;
            sym_re_o          = {beat_re_i[31:0], carry_re_i[31:0]};
            sym_im_o          = {beat_im_i[31:0], carry_im_i[31:0]};
            carry_re_o[15:0]  = beat_re_i[63:48];
            carry_im_o[15:0]  = beat_im_i[63:48];
         end
         3'd3: begin
            emit_o   = 1'b1;
            sym_re_o = {beat_re_i[47:0], carry_re_i[15:0]};
            sym_im_o = {beat_im_i[47:0], carry_im_i[15:0]};
         end
         3'd4: begin
            emit_o   = 1'b1;
            sym_re_o = beat_re_i;
            sym_im_o = beat_im_i;
         end
         default: begin
            emit_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rx_cp_remover.sv
// Strips the 16-sample cyclic prefix from 80-sample OFDM symbols arriving 64 samples per beat
// and emits one 64-lane FFT input vector per symbol.
module rx_cp_remover
   import rx_pkg::*;
#(
   parameter int unsigned PHASES   = 64,
   parameter int unsigned BITWIDTH = 12,
   parameter int unsigned FFTN     = 64,
   parameter int unsigned CPLEN    = 16,
   parameter int unsigned NUMSYM   = 12
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [BITWIDTH*PHASES-1:0]   rx_re_i,
   input  logic [BITWIDTH*PHASES-1:0]   rx_im_i,
   input  logic                         rx_valid_i,
   input  logic                         frame_start_i,
   output logic [BITWIDTH*FFTN-1:0]     sym_re_o,
   output logic [BITWIDTH*FFTN-1:0]     sym_im_o,
   output logic                         sym_valid_o,
   output logic [$clog2(NUMSYM)-1:0]    sym_idx_o,
   output logic                         frame_done_o,
   output logic                         abort_o
);

   localparam int unsigned IdxW = $clog2(NUMSYM);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUMSYM - 1);
   localparam phase_t LastPhase = phase_t'(GROUP_BEATS - 1);

   if (PHASES != FFT_LEN || FFTN != FFT_LEN || CPLEN != CP_LEN) begin : g_bad_geometry
      $error("rx_cp_remover supports only PHASES=FFTN=64 and CPLEN=16");
   end
   if (NUMSYM % GROUP_SYMS != 0) begin : g_bad_numsym
      $error("rx_cp_remover requires NUMSYM to be a multiple of 4");
   end

   typedef logic [FFT_LEN-1:0][BITWIDTH-1:0]     vec_t;
   typedef logic [CARRY_LANES-1:0][BITWIDTH-1:0] carry_t;

   state_e          state_q, state_d;
   phase_t          phase_q, phase_d;
   logic [IdxW-1:0] sym_cnt_q, sym_cnt_d;
   carry_t          carry_re_q, carry_re_d, carry_im_q, carry_im_d;
   vec_t            sym_re_q, sym_re_d, sym_im_q, sym_im_d;
   logic            sym_valid_q, sym_valid_d;
   logic [IdxW-1:0] sym_idx_q, sym_idx_d;
   logic            frame_done_q, frame_done_d;
   logic            abort_q, abort_d;

   vec_t            beat_re, beat_im, slice_re, slice_im;
   carry_t          next_carry_re, next_carry_im;
   phase_t          slice_phase;
   logic            slice_emit;

   assign beat_re = rx_re_i;
   assign beat_im = rx_im_i;
   // A frame start beat is always b0, whatever phase the old frame had reached.
   assign slice_phase = frame_start_i ? phase_t'(0) : phase_q;

   rx_cp_slicer #(
      .BITWIDTH (BITWIDTH)
   ) u_slicer (
      .phase_i    (slice_phase),
      .beat_re_i  (beat_re),
      .beat_im_i  (beat_im),
      .carry_re_i (carry_re_q),
      .carry_im_i (carry_im_q),
      .sym_re_o   (slice_re),
      .sym_im_o   (slice_im),
      .carry_re_o (next_carry_re),
      .carry_im_o (next_carry_im),
      .emit_o     (slice_emit)
   );

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      sym_cnt_d    = sym_cnt_q;
      carry_re_d   = carry_re_q;
      carry_im_d   = carry_im_q;
      sym_re_d     = sym_re_q;
      sym_im_d     = sym_im_q;
      sym_idx_d    = sym_idx_q;
      sym_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      abort_d      = 1'b0;
      if (rx_valid_i) begin
         if (frame_start_i) begin
            abort_d    = (state_q == StActive);
            state_d    = StActive;
            phase_d    = phase_t'(1);
            sym_cnt_d  = '0;
            carry_re_d = next_carry_re;
            carry_im_d = next_carry_im;
         end else if (state_q == StActive) begin
            carry_re_d = next_carry_re;
            carry_im_d = next_carry_im;
            phase_d    = (phase_q == LastPhase) ? phase_t'(0) : phase_q + phase_t'(1);
            if (slice_emit) begin
               sym_valid_d  = 1'b1;
               sym_re_d     = slice_re;
               sym_im_d     = slice_im;
               sym_idx_d    = sym_cnt_q;
               frame_done_d = (sym_cnt_q == LastIdx);
               if (sym_cnt_q == LastIdx) begin
                  state_d   = StIdle;
                  sym_cnt_d = '0;
                  phase_d   = phase_t'(0);
               end else begin
                  sym_cnt_d = sym_cnt_q + IdxW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         phase_q      <= '0;
         sym_cnt_q    <= '0;
         carry_re_q   <= '0;
         carry_im_q   <= '0;
         sym_re_q     <= '0;
         sym_im_q     <= '0;
         sym_valid_q  <= 1'b0;
         sym_idx_q    <= '0;
         frame_done_q <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         sym_cnt_q    <= sym_cnt_d;
         carry_re_q   <= carry_re_d;
         carry_im_q   <= carry_im_d;
         sym_re_q     <= sym_re_d;
         sym_im_q     <= sym_im_d;
         sym_valid_q  <= sym_valid_d;
         sym_idx_q    <= sym_idx_d;
         frame_done_q <= frame_done_d;
         abort_q      <= abort_d;
      end
   end

   assign sym_re_o     = sym_re_q;
   assign sym_im_o     = sym_im_q;
   assign sym_valid_o  = sym_valid_q;
   assign sym_idx_o    = sym_idx_q;
   assign frame_done_o = frame_done_q;
   assign abort_o      = abort_q;

endmodule
